// File: rtl/multiport_memory_controller_pkg.sv
// Shared types and constants for the PDP-8 main-memory controller.
package memory_utils;

    typedef enum logic [1:0] {
        MC_IDLE   = 2'd0,
        MC_ACCESS = 2'd1,
        MC_DONE   = 2'd2
    } mc_state_t;

    localparam logic DATA_READ         = 1'b0;
    localparam logic INSTRUCTION_FETCH = 1'b1;

    localparam int WORD_W = 12;
    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/multiport_memory_controller_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after the pointer wins.
module rr_arbiter #(
    parameter int N_PORTS = 2,
    parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // scan ports ptr+1 .. ptr+N_PORTS (mod N_PORTS), keep the first requester
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand_s = IDX_W'((int'(ptr) + i) % N_PORTS);
            if (!found_s && req[cand_s]) begin
                found_s       = 1'b1;
                idx           = cand_s;
                grant[cand_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/multiport_memory_controller.sv
// Round-robin multi-port PDP-8 memory controller: one access at a time with
// programmable wait states and a per-word valid bit.
module multiport_memory_controller
    import memory_utils::*;
#(
    parameter int N_PORTS     = 2,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS-1:0]        we,
    input  logic [N_PORTS-1:0]        read_type,
    input  logic [N_PORTS*ADDR_W-1:0] addr,
    input  logic [N_PORTS*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_PORTS-1:0]        done,
    output logic                      rd_invalid,
    output logic                      busy
);

    localparam int         IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    // Both read flavours return the stored word; unknown types behave as data reads.
    function automatic logic [DATA_W-1:0] read_word(input logic rt, input logic v,
                                                    input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        case (rt)
            INSTRUCTION_FETCH: r = v ? w : '0;
            DATA_READ:         r = v ? w : '0;
            default:           r = v ? w : '0;
        endcase
        return r;
    endfunction

    mc_state_t           state_r, state_s;
    logic [IDX_W-1:0]    ptr_r;
    logic [N_PORTS-1:0]  arb_grant_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic [N_PORTS-1:0]  grant_r;
    logic                we_r;
    logic                rt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [3:0]          cnt_r;
    logic [N_PORTS-1:0]  done_r;
    logic                rd_invalid_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                busy_r;
    logic                start_s;
    logic                commit_s;
    logic [DEPTH-1:0]    valid_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s)
    );

    assign start_s  = (state_r == MC_IDLE) && (|req);
    assign commit_s = (state_r == MC_ACCESS) && (cnt_r == 4'd0);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= MC_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next-state logic; DONE always falls back to IDLE so grants never run back to back
    always_comb begin
        state_s = state_r;
        case (state_r)
            MC_IDLE:   state_s = (|req) ? MC_ACCESS : MC_IDLE;
            MC_ACCESS: state_s = (cnt_r == 4'd0) ? MC_DONE : MC_ACCESS;
            MC_DONE:   state_s = MC_IDLE;
            default:   state_s = MC_IDLE;
        endcase
    end

    // grant latch, wait counter and registered completion outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r        <= IDX_W'(N_PORTS - 1);
            grant_r      <= '0;
            we_r         <= 1'b0;
            rt_r         <= DATA_READ;
            addr_r       <= '0;
            wdata_r      <= '0;
            cnt_r        <= 4'd0;
            done_r       <= '0;
            rd_invalid_r <= 1'b0;
            rdata_r      <= '0;
            busy_r       <= 1'b0;
        end else begin
            done_r       <= '0;
            rd_invalid_r <= 1'b0;
            busy_r       <= (state_s != MC_IDLE);
            if (start_s) begin
                ptr_r   <= arb_idx_s;
                grant_r <= arb_grant_s;
                we_r    <= we[arb_idx_s];
                rt_r    <= read_type[arb_idx_s];
                addr_r  <= addr[arb_idx_s*ADDR_W +: ADDR_W];
                wdata_r <= wdata[arb_idx_s*DATA_W +: DATA_W];
                cnt_r   <= WS;
            end else if (state_r == MC_ACCESS && cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (commit_s) begin
                done_r <= grant_r;
                if (!we_r) begin
                    rdata_r      <= read_word(rt_r, valid_r[addr_r], mem_r[addr_r]);
                    rd_invalid_r <= ~valid_r[addr_r];
                end else begin
                    rdata_r <= rdata_r;
                end
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // per-word valid bits, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (commit_s && we_r) begin
            valid_r[addr_r] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // array contents survive reset, but a reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (rst_n && commit_s && we_r) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

    assign rdata      = rdata_r;
    assign done       = done_r;
    assign rd_invalid = rd_invalid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_multiport_memory_controller.sv
// Directed self-checking bench: table of single-port transactions plus
// hand-written sequences for arbitration, wait states, dropped req and reset.
module tb_multiport_memory_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, rt;
    logic [23:0] addr, wdata;
    logic [11:0] rdata;
    logic [1:0]  done;
    logic        rd_invalid, busy;

    logic [1:0]  req_w, we_w, rt_w;
    logic [23:0] addr_w, wdata_w;
    logic [11:0] rdata_w;
    logic [1:0]  done_w;
    logic        inv_w, busy_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multiport_memory_controller #(.N_PORTS(2), .ADDR_W(12), .DATA_W(12), .WAIT_STATES(0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .read_type(rt), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .rd_invalid(rd_invalid), .busy(busy)
    );

    multiport_memory_controller #(.N_PORTS(2), .ADDR_W(12), .DATA_W(12), .WAIT_STATES(3)) dut_ws (
        .clk(clk), .rst_n(rst_n), .req(req_w), .we(we_w), .read_type(rt_w), .addr(addr_w),
        .wdata(wdata_w), .rdata(rdata_w), .done(done_w), .rd_invalid(inv_w), .busy(busy_w)
    );

    typedef struct {
        int         port;
        logic       w;
        logic       rtype;
        logic [11:0] a;
        logic [11:0] d;
        logic [11:0] exp_rdata;
        logic        exp_inv;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // one transaction on the zero-wait-state controller, port p alone requesting
    task automatic do_op(input int p, input logic w, input logic t, input logic [11:0] a,
                         input logic [11:0] d, input logic [11:0] er, input logic ei);
        int k;
        bit seen;
        @(negedge clk);
        req[p] = 1'b1; we[p] = w; rt[p] = t;
        addr[p*12 +: 12] = a; wdata[p*12 +: 12] = d;
        seen = 1'b0; k = 0;
        while (!seen && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (done != 2'b00) seen = 1'b1;
        end
        check("latency", k, 2);
        check("done_port", {30'd0, done}, 32'd1 << p);
        check("rdata", {20'd0, rdata}, {20'd0, er});
        check("rd_invalid", {31'd0, rd_invalid}, {31'd0, ei});
        @(negedge clk);
        req[p] = 1'b0;
        @(posedge clk); #1;
        check("done_width", {30'd0, done}, 32'd0);
    endtask

    initial begin
        int nd, nb, dcyc;

        tbl[0] = '{0, 1'b0, 1'b0, 12'o0100, 12'o0000, 12'o0000, 1'b1};
        tbl[1] = '{0, 1'b1, 1'b0, 12'o0200, 12'o7777, 12'o0000, 1'b0};
        tbl[2] = '{1, 1'b0, 1'b0, 12'o0200, 12'o0000, 12'o7777, 1'b0};
        tbl[3] = '{1, 1'b1, 1'b0, 12'o0017, 12'o5252, 12'o7777, 1'b0};
        tbl[4] = '{0, 1'b0, 1'b1, 12'o0017, 12'o0000, 12'o5252, 1'b0};
        tbl[5] = '{1, 1'b1, 1'b0, 12'o7777, 12'o0001, 12'o5252, 1'b0};
        tbl[6] = '{0, 1'b0, 1'b0, 12'o7777, 12'o0000, 12'o0001, 1'b0};
        tbl[7] = '{1, 1'b0, 1'b1, 12'o0000, 12'o0000, 12'o0000, 1'b1};
        tbl[8] = '{0, 1'b1, 1'b0, 12'o0000, 12'o4321, 12'o0000, 1'b0};
        tbl[9] = '{1, 1'b0, 1'b0, 12'o0000, 12'o0000, 12'o4321, 1'b0};

        rst_n = 1'b0;
        req = 2'b00; we = 2'b00; rt = 2'b00; addr = '0; wdata = '0;
        req_w = 2'b00; we_w = 2'b00; rt_w = 2'b00; addr_w = '0; wdata_w = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_rd_invalid", {31'd0, rd_invalid}, 32'd0);
        check("rst_rdata", {20'd0, rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // wait-state controller: single read of an unwritten word
        @(negedge clk);
        req_w = 2'b01; addr_w[11:0] = 12'o0100;
        nb = 0; dcyc = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (busy_w) nb++;
            if (done_w != 2'b00) begin
                dcyc = c;
                req_w = 2'b00;
                check("ws_done_port", {30'd0, done_w}, 32'd1);
                check("ws_rdata", {20'd0, rdata_w}, 32'd0);
                check("ws_rd_invalid", {31'd0, inv_w}, 32'd1);
            end
        end
        check("ws_latency", dcyc, 5);
        check("ws_busy_cycles", nb, 5);

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].port, tbl[i].w, tbl[i].rtype, tbl[i].a, tbl[i].d,
                  tbl[i].exp_rdata, tbl[i].exp_inv);
        end

        // port 1 abandons req right after its grant; the read still completes once
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; rt[1] = 1'b0; addr[23:12] = 12'o0200;
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        nd = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done != 2'b00) begin
                nd++;
                check("drop_done_port", {30'd0, done}, 32'd2);
                check("drop_rdata", {20'd0, rdata}, 32'o7777);
            end
        end
        check("drop_done_count", nd, 1);

        // reset on the commit edge of a write
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[11:0] = 12'o0300; wdata[11:0] = 12'o1111;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; req[0] = 1'b0; we[0] = 1'b0;
        @(posedge clk); #1;
        check("rstc_done", {30'd0, done}, 32'd0);
        check("rstc_busy", {31'd0, busy}, 32'd0);
        check("rstc_rdata", {20'd0, rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 1'b0, 1'b0, 12'o0300, 12'o0000, 12'o0000, 1'b1);

        // both ports hold req from reset: grants alternate 0,1,0,1 every 3 cycles
        @(negedge clk);
        rst_n = 1'b0;
        req = 2'b11; we = 2'b00; rt = 2'b00;
        addr[11:0] = 12'o0100; addr[23:12] = 12'o0200;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (done != 2'b00) begin
                if (nd < 4) begin
                    check("rr_port", {30'd0, done}, (nd % 2 == 0) ? 32'd1 : 32'd2);
                    check("rr_cycle", c, 2 + 3 * nd);
                    check("rr_rd_invalid", {31'd0, rd_invalid}, 32'd1);
                end
                nd++;
            end
        end
        check("rr_done_count", nd, 4);
        @(negedge clk);
        req = 2'b00;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
